// File: rtl/sha256_frame_sequencer.sv
// Frame sequencer between UART byte streams and a single-block SHA-256 core.
// Optional inter-byte receive timeout: define SHA_SEQ_TIMEOUT_EN.
module sha256_frame_sequencer #(
    parameter int         MAX_LEN        = 55,
    parameter logic [7:0] ERR_BYTE       = 8'hEE,
    parameter int         TIMEOUT_CYCLES = 27000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         core_wr,
    output logic [3:0]   core_addr,
    output logic [31:0]  core_wdata,
    output logic         core_start,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         busy,
    output logic         done_toggle
);
    typedef enum logic [2:0] {
        IDLE, RECV, PAD, LOAD, START, WAIT, SEND, ERR
    } state_t;

    localparam logic [7:0] MAXL = 8'(MAX_LEN);

    if (MAX_LEN > 55 || MAX_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("sha256_frame_sequencer: invalid parameter");
    end

    state_t       state, state_nx;
    logic [7:0]   mem [64];
    logic [7:0]   len;
    logic [5:0]   cnt;
    logic [3:0]   widx;
    logic [4:0]   bidx;
    logic [255:0] digest;
    logic [10:0]  bits;
    logic         rx_fire, tx_fire, tmo;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;
    assign bits    = {len, 3'b000};
    assign busy    = (state != IDLE);

`ifdef SHA_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (state != RECV || rx_fire)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end

    // fires on the TIMEOUT_CYCLES-th consecutive idle cycle in RECV
    assign tmo = (state == RECV) && !rx_valid &&
                 (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        core_wr    = 1'b0;
        core_addr  = 4'd0;
        core_wdata = 32'd0;
        core_start = 1'b0;
        unique case (state)
            IDLE: begin
                rx_ready = rst_n;
                if (rx_valid) begin
                    if (rx_data > MAXL)       state_nx = ERR;
                    else if (rx_data == 8'd0) state_nx = PAD;
                    else                      state_nx = RECV;
                end
            end
            RECV: begin
                rx_ready = rst_n;
                if (rx_valid) begin
                    if (cnt == len[5:0] - 6'd1) state_nx = PAD;
                end else if (tmo) begin
                    state_nx = ERR;
                end
            end
            PAD: state_nx = LOAD;
            LOAD: begin
                core_wr    = 1'b1;
                core_addr  = widx;
                core_wdata = {mem[{widx, 2'd0}], mem[{widx, 2'd1}],
                              mem[{widx, 2'd2}], mem[{widx, 2'd3}]};
                if (widx == 4'd15) state_nx = START;
            end
            START: begin
                core_start = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: if (core_done) state_nx = SEND;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = digest[{~bidx, 3'b000} +: 8];
                if (tx_ready && bidx == 5'd31) state_nx = IDLE;
            end
            ERR: begin
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 64; j++) mem[6'(j)] <= 8'h00;
            len         <= 8'd0;
            cnt         <= 6'd0;
            widx        <= 4'd0;
            bidx        <= 5'd0;
            digest      <= '0;
            done_toggle <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (rx_fire) begin
                    len <= rx_data;
                    cnt <= 6'd0;
                end
                RECV: if (rx_fire) begin
                    mem[cnt] <= rx_data;
                    cnt      <= cnt + 6'd1;
                end
                PAD: begin
                    // message bytes below len stay; terminator, zero fill, bit length
                    for (int j = 0; j < 62; j++) begin
                        if (6'(j) == len[5:0])     mem[6'(j)] <= 8'h80;
                        else if (6'(j) > len[5:0]) mem[6'(j)] <= 8'h00;
                    end
                    mem[62] <= {5'd0, bits[10:8]};
                    mem[63] <= bits[7:0];
                    widx    <= 4'd0;
                end
                LOAD: widx <= widx + 4'd1;
                WAIT: if (core_done) begin
                    digest <= core_digest;
                    bidx   <= 5'd0;
                end
                SEND: if (tx_fire) begin
                    bidx <= bidx + 5'd1;
                    if (bidx == 5'd31) done_toggle <= ~done_toggle;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_frame_sequencer.sv
// Randomized self-checking bench for sha256_frame_sequencer with a
// behavioural SHA-256 core model and a padding/digest reference model.
module tb_sha256_frame_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         core_wr;
    logic [3:0]   core_addr;
    logic [31:0]  core_wdata;
    logic         core_start;
    logic         core_done;
    logic [255:0] core_digest;
    logic         busy;
    logic         done_toggle;

    sha256_frame_sequencer #(.MAX_LEN(55), .ERR_BYTE(8'hEE), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_start(core_start), .core_done(core_done), .core_digest(core_digest),
        .busy(busy), .done_toggle(done_toggle)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    int          ncheck = 0, npass = 0;
    int          cyc = 0, hs_cyc = 0, pos = 0, stall_n = 0;
    int          nstart = 0, nwr = 0, exp_starts = 0, exp_wr = 0;
    logic        exp_tog = 1'b0, recv_phase = 1'b0;
    logic [3:0]  exp_k = 4'd0;
    logic [31:0] exp_blk [16];
    logic [31:0] blk [16];
    logic [7:0]  txq [$];
    logic [7:0]  got [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [31:0] m [16]);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = H0[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        return {H0[0] + v[0], H0[1] + v[1], H0[2] + v[2], H0[3] + v[3],
                H0[4] + v[4], H0[5] + v[5], H0[6] + v[6], H0[7] + v[7]};
    endfunction

    // standard message padding: msg, 0x80, zeros to 56 bytes, 64-bit bit length
    task automatic build(input logic [7:0] msg [$]);
        logic [7:0]  b [$];
        logic [63:0] nbits;
        b = msg;
        b.push_back(8'h80);
        while (b.size() < 56) b.push_back(8'h00);
        nbits = 64'(msg.size()) * 64'd8;
        for (int j = 7; j >= 0; j--) b.push_back(nbits[8*j +: 8]);
        for (int k = 0; k < 16; k++) exp_blk[k] = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
    endtask

    always @(posedge clk) cyc++;

    // SHA-256 core stand-in: hashes whatever block was written
    initial begin
        int  lat;
        logic pend;
        core_done = 1'b0; core_digest = '0; pend = 1'b0; lat = 0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (!rst_n) pend = 1'b0;
            else begin
                if (core_wr) begin blk[core_addr] = core_wdata; nwr++; end
                if (core_start) begin nstart++; pend = 1'b1; lat = $urandom_range(0, 10); end
                else if (pend) begin
                    if (lat == 0) begin
                        core_digest = sha_blk(blk); core_done = 1'b1; pend = 1'b0;
                    end else lat--;
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_n > 0 && pos == 5 && tx_valid) begin tx_ready = 1'b0; stall_n--; end
            else tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // compare process
    initial begin
        logic       pv, pr;
        logic [7:0] pd, e;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 1'b0;
            else begin
                if (rx_valid && rx_ready) hs_cyc = cyc + 1;
                if (!busy) chk("rx_ready_idle", 64'(rx_ready), 64'd1);
                else if (!recv_phase) chk("rx_ready_busy", 64'(rx_ready), 64'd0);
                if (pv && !pr) chk("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, pd});
                if (tx_valid && tx_ready) begin
                    if (txq.size() == 0) chk("tx_unexpected", 64'(tx_valid), 64'd0);
                    else begin
                        e = txq.pop_front();
                        chk("tx_byte", 64'(tx_data), 64'(e));
                        got.push_back(tx_data);
                        pos++;
                    end
                end
                if (core_wr) begin
                    if (exp_k == 4'd0) chk("load_latency", 64'(cyc - hs_cyc), 64'd1);
                    chk("core_addr", 64'(core_addr), 64'(exp_k));
                    chk("core_wdata", 64'(core_wdata), 64'(exp_blk[exp_k]));
                    exp_k = exp_k + 4'd1;
                end
                if (core_start) chk("start_latency", 64'(cyc - hs_cyc), 64'd17);
                pv = tx_valid; pr = tx_ready; pd = tx_data;
            end
        end
    end

    task automatic rx_byte(input logic [7:0] b, input logic rp);
        int n;
        n = 0;
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'($urandom); recv_phase = rp;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input logic [7:0] L, input logic [7:0] msg [$]);
        logic [255:0] d;
        int n;
        got.delete(); pos = 0;
        if (L > 8'd55) txq.push_back(8'hEE);
        else begin
            build(msg);
            d = sha_blk(exp_blk);
            for (int i = 0; i < 32; i++) txq.push_back(d[255-8*i -: 8]);
            exp_starts++; exp_wr += 16; exp_tog = ~exp_tog; exp_k = 4'd0;
        end
        rx_byte(L, (L >= 8'd1 && L <= 8'd55));
        if (L <= 8'd55)
            for (int i = 0; i < int'(L); i++) rx_byte(msg[i], (i < int'(L) - 1));
        n = 0;
        while (txq.size() != 0 && n < 4000) begin @(negedge clk); n++; end
        chk("tx_drain", 64'(txq.size()), 64'd0);
        @(negedge clk);
        chk("busy_end", 64'(busy), 64'd0);
        chk("done_toggle", 64'(done_toggle), 64'(exp_tog));
        chk("core_starts", 64'(nstart), 64'(exp_starts));
        chk("core_writes", 64'(nwr), 64'(exp_wr));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        txq.delete(); exp_tog = 1'b0; recv_phase = 1'b0; exp_k = 4'd0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] first4();
        return {got[0], got[1], got[2], got[3]};
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   m [$];
        logic [255:0] d;
        logic [7:0]   L;
        int           n;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) begin @(posedge clk); #1; end
        chk("reset_outputs", {14'd0, rx_ready, tx_valid, tx_data, core_wr, core_addr,
            core_wdata, core_start, busy, done_toggle}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_rx_ready", {62'd0, busy, rx_ready}, 64'd1);

        m = '{8'h61, 8'h62, 8'h63};
        build(m);
        d = sha_blk(exp_blk);
        chk("model_abc_w0", 64'(exp_blk[0]), 64'h61626380);
        chk("model_abc_w15", 64'(exp_blk[15]), 64'h18);
        chk("model_abc_hi", 64'(d[255:224]), 64'hba7816bf);
        chk("model_abc_lo", 64'(d[31:0]), 64'hf20015ad);

        run_frame(8'd3, m);
        chk("abc_first", 64'(first4()), 64'hBA7816BF);
        chk("abc_last", 64'({got[28], got[29], got[30], got[31]}), 64'hF20015AD);

        m = {};
        build(m);
        chk("model_empty_w0", 64'(exp_blk[0]), 64'h80000000);
        run_frame(8'd0, m);
        chk("empty_first", 64'(first4()), 64'hE3B0C442);

        run_frame(8'd56, m);
        chk("reject_byte", 64'(got.size() > 0 ? got[0] : 8'h00), 64'hEE);
        m = '{8'h41};
        run_frame(8'd1, m);
        chk("A_first", 64'(first4()), 64'h559AEAD0);

        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'($urandom));
        stall_n = 10;
        run_frame(8'd55, m);
        chk("stall_used", 64'(stall_n), 64'd0);

        // reset in the middle of the block load
        m = '{8'h61, 8'h62, 8'h63};
        build(m); exp_k = 4'd0;
        rx_byte(8'd3, 1'b1); rx_byte(m[0], 1'b1); rx_byte(m[1], 1'b1); rx_byte(m[2], 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!(core_wr && core_addr == 4'd7) && n < 100);
        chk("reached_k7", 64'(n < 100), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {14'd0, rx_ready, tx_valid, tx_data, core_wr, core_addr,
            core_wdata, core_start, busy, done_toggle}, 64'd0);
        exp_wr += 8;
        txq.delete(); exp_tog = 1'b0; recv_phase = 1'b0; exp_k = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        chk("no_start_after_reset", 64'(nstart), 64'(exp_starts));
        run_frame(8'd3, m);
        chk("abc_after_reset", 64'(first4()), 64'hBA7816BF);

        for (int f = 0; f < 16; f++) begin
            L = (f == 15) ? 8'hFF : 8'($urandom_range(0, 60));
            m = {};
            if (L <= 8'd55)
                for (int i = 0; i < int'(L); i++) m.push_back(8'($urandom));
            run_frame(L, m);
        end

        // receive timeout
`ifdef SHA_SEQ_TIMEOUT_EN
        txq.push_back(8'hEE);
`endif
        rx_byte(8'd4, 1'b1); rx_byte(8'h61, 1'b1);
        n = 0;
        while (!tx_valid && n < 200) begin @(negedge clk); n++; end
`ifdef SHA_SEQ_TIMEOUT_EN
        chk("timeout_cycles", 64'(cyc - hs_cyc), 64'd100);
        n = 0;
        while ((busy || txq.size() != 0) && n < 200) begin @(negedge clk); n++; end
        chk("timeout_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        recv_phase = 1'b0;
`else
        chk("no_timeout_tx", 64'(tx_valid), 64'd0);
        do_reset();
`endif
        chk("timeout_no_start", 64'(nstart), 64'(exp_starts));
        m = '{8'h41};
        run_frame(8'd1, m);
        chk("A_after_timeout", 64'(first4()), 64'h559AEAD0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule
